out_streamer: RTL
=================

# out_streamer

Responder side of the `out_start`/`out_done` handshake issued by the model controller after the final layer. It snapshots the final hidden vector when `out_start` arrives, then streams it out as fixed-width beats over a valid/ready interface. It returns a one-cycle `out_done` once the last beat has been accepted. It sits between the last layer's output register and the off-chip/host write path.

## Interface
- `HIDDEN`, default 768: elements per hidden vector.
- `ACT_BITWIDTH`, default 4: bits per element.
- `LANES`, default 32: elements per output beat. `HIDDEN % LANES == 0` is required; elaboration fails otherwise.
- Derived: `BEATS = HIDDEN/LANES` (24 at defaults); `CNT_W = $clog2(BEATS)`, minimum 1.

Ports:
- `clk`  in  1  single clock. Everything is rising-edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `out_start`  in  1  single-cycle start pulse from the model controller.
- `hidden_in`  in  `HIDDEN*ACT_BITWIDTH`  final hidden vector. Element i is at bits `[i*ACT_BITWIDTH +: ACT_BITWIDTH]`. Valid in the cycle `out_start` is high.
- `m_valid`  out  1  beat valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_data`  out  `LANES*ACT_BITWIDTH`  beat payload.
- `m_last`  out  1  high on the final beat of the vector.
- `out_done`  out  1  single-cycle completion pulse.
- `busy`  out  1  high in `STREAM` state.
- `start_err`  out  1  sticky flag: `out_start` was seen while not accepting. Cleared only by reset.

## Operation
- States: `IDLE`, `STREAM`, `DONE`.
- **IDLE:** on `out_start`, capture `hidden_in` into the shadow register, clear the beat counter, go to `STREAM`.
- **STREAM:**
  - `m_valid=1`.
  - `m_data` = shadow elements `[beat*LANES +: LANES]`, lowest elements first.
  - `m_last = (beat == BEATS-1)`.
  - On `m_valid && m_ready`, the counter increments. If the accepted beat is the last one, go to `DONE`.
- **DONE:** `out_done=1` for exactly this cycle. If `out_start` is high in this cycle, treat it as in `IDLE` (capture, go to `STREAM`); otherwise go to `IDLE`.
- `out_start` while in `STREAM`:
  - ignored;
  - shadow and counter are unaffected;
  - `start_err` sets the next cycle.
- Payload is registered from the shadow register only. `hidden_in` may change freely after the capture cycle.
- The counter never wraps mid-vector. It resets only on capture or reset.

## Timing
- Reset values: `m_valid=0`, `m_last=0`, `m_data=0`, `out_done=0`, `busy=0`, `start_err=0`. State is `IDLE`, counter is 0, shadow is 0.
- Reset asserted mid-stream: all outputs go to the reset values immediately. The partial vector is dropped and no `out_done` is produced.
- `out_start` sampled at edge T: `m_valid` and `busy` go high after edge T. The first beat is presentable in cycle T+1.
- While `m_valid=1 && m_ready=0`: `m_data` and `m_last` hold stable. `m_valid` never drops before acceptance.
- With `m_ready` held high, beat k is accepted at cycle T+1+k. The last beat is accepted at T+BEATS. `out_done` is high in cycle T+BEATS+1. Minimum start-to-done latency is BEATS+1 cycles.
- Back-to-back: an `out_start` coinciding with `out_done` yields the next first beat in the following cycle. No bubble other than the `DONE` cycle.
- `m_ready` is ignored when `m_valid=0`. No combinational path from `m_ready` to `m_valid`.

## Structure
- Shared accelerator package holds:
  - the state enum `out_state_e` (`IDLE`, `STREAM`, `DONE`);
  - `HIDDEN` and `ACT_BITWIDTH` defaults;
  - the `BEATS` derivation function shared with other stage responders.
- One natural sub-module: `beat_mux`. It is combinational and selects the `LANES`-element slice of the shadow register by beat index; the result is registered in `out_streamer`.
- Everything else (FSM, counter, shadow, error flag) stays in `out_streamer`.

## Test plan
1. **Reset and capture:** reset, then `out_start` with element i = i mod 16, `m_ready=1`.
   - 24 beats. Beat 0 carries elements 0..31 (values 0..15,0..15).
   - `m_last` only on beat 23.
   - `out_done` exactly at T+25.
2. **Backpressure:** `m_ready` toggles 1,0,0,1, repeating.
   - `m_data`/`m_last` stable during every stall.
   - All 24 beats are correct and in order.
   - `out_done` one cycle after the final acceptance.
3. **Busy start:** `out_start` at beat 5 with a different vector.
   - Output still carries the original vector.
   - `start_err=1` from the next cycle and stays set.
   - Exactly one `out_done`.
4. **Back-to-back:** second `out_start` coincident with `out_done`, new vector of all 0xA.
   - First beat of the new vector appears the next cycle.
   - `start_err` remains 0.
5. **Mid-stream reset:** `rstn` low at beat 10.
   - All outputs 0 asynchronously; no `out_done`.
   - A fresh `out_start` restarts from beat 0.
6. **Input isolation:** `hidden_in` randomized every cycle after capture → the streamed data equals the captured snapshot.

Source files
------------

// File: rtl/out_streamer_pkg.sv
// Shared accelerator definitions for the output-stage responder: state enum,
// default sizing and the beat-count derivation used by stage responders.
package out_streamer_pkg;

  localparam int unsigned HIDDEN_DEF       = 768;
  localparam int unsigned ACT_BITWIDTH_DEF = 4;
  localparam int unsigned LANES_DEF        = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } out_state_e;

  // Beats needed to move one hidden vector at the given lane count
  function automatic int unsigned calc_beats(input int unsigned hidden, input int unsigned lanes);
    return hidden / lanes;
  endfunction

  // Beat counter width, never narrower than one bit
  function automatic int unsigned calc_cnt_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/out_streamer_if.sv
// Valid/ready beat stream carrying one slice of the hidden vector per transfer.
interface out_streamer_if #(
  parameter int unsigned DATA_W = 128
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/out_streamer_beat_mux.sv
// Selects the LANES-element slice of a vector addressed by beat index;
// out-of-range indices yield zero.
module beat_mux #(
  parameter int unsigned LANES        = 32,
  parameter int unsigned ACT_BITWIDTH = 4,
  parameter int unsigned BEATS        = 24,
  parameter int unsigned CNT_W        = 5
) (
  input  logic [BEATS*LANES*ACT_BITWIDTH-1:0] vec,
  input  logic [CNT_W-1:0]                    beat,
  output logic [LANES*ACT_BITWIDTH-1:0]       slice_c
);

  localparam int unsigned SLICE_W = LANES * ACT_BITWIDTH;

  always_comb begin
    slice_c = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat == CNT_W'(b)) slice_c = vec[b*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/out_streamer.sv
// Output-stage responder: snapshots the final hidden vector on out_start and
// streams it as LANES-wide beats, pulsing out_done after the last acceptance.
module out_streamer
  import out_streamer_pkg::*;
#(
  parameter int unsigned HIDDEN       = HIDDEN_DEF,
  parameter int unsigned ACT_BITWIDTH = ACT_BITWIDTH_DEF,
  parameter int unsigned LANES        = LANES_DEF
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           out_start,
  input  logic [HIDDEN*ACT_BITWIDTH-1:0] hidden_in,
  out_streamer_if.master                 m,
  output logic                           out_done,
  output logic                           busy,
  output logic                           start_err
);

  localparam int unsigned BEATS  = calc_beats(HIDDEN, LANES);
  localparam int unsigned CNT_W  = calc_cnt_w(BEATS);
  localparam int unsigned VEC_W  = HIDDEN * ACT_BITWIDTH;
  localparam int unsigned BEAT_W = LANES * ACT_BITWIDTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (HIDDEN % LANES != 0) begin : g_bad_lanes
    $error("out_streamer: HIDDEN must be a multiple of LANES");
  end

  out_state_e        state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [VEC_W-1:0]  shadow_q, shadow_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [BEAT_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              accept_c;
  logic [BEAT_W-1:0] mux_slice_c;

  // Slice is taken from the next-cycle shadow so the first beat is ready right after capture
  beat_mux #(
    .LANES        (LANES),
    .ACT_BITWIDTH (ACT_BITWIDTH),
    .BEATS        (BEATS),
    .CNT_W        (CNT_W)
  ) u_beat_mux (
    .vec     (shadow_d),
    .beat    (beat_d),
    .slice_c (mux_slice_c)
  );

  // Next-state, counter, shadow and output decode
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    accept_c = valid_q && m.m_ready;

    case (state_q)
      STREAM: begin
        if (out_start) err_d = 1'b1;
        if (accept_c) begin
          if (beat_q == LAST_BEAT) state_d = DONE;
          else                     beat_d  = beat_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        if (out_start) begin
          shadow_d = hidden_in;
          beat_d   = '0;
          state_d  = STREAM;
        end
      end
    endcase

    valid_d = (state_d == STREAM);
    busy_d  = (state_d == STREAM);
    done_d  = (state_d == DONE);
    last_d  = valid_d && (beat_d == LAST_BEAT);
    data_d  = valid_d ? mux_slice_c : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      data_q   <= data_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign m.m_valid = valid_q;
  assign m.m_last  = last_q;
  assign m.m_data  = data_q;
  assign out_done  = done_q;
  assign busy      = busy_q;
  assign start_err = err_q;

endmodule
